hazard_stall_ctrl: RTL and testbench

- Stall/flush controller for the 5-stage MIPS pipeline.
- Holds a shadow copy of destination register and Tnew for the instructions in the E and M stages. Each cycle it compares the D-stage operand Tuse against those copies to decide stalls.
- Tracks mult/div busy time with an internal counter and stalls HI/LO users while the multiply/divide unit (MDU) is busy.
- Drives the PC enable, the D register stall and the E register flush; on a stall the D register holds its contents.

---
 rtl/hazard_stall_ctrl_pkg.sv | 43 ++++
 rtl/hazard_stall_ctrl_md_busy_counter.sv | 42 ++++
 rtl/hazard_stall_ctrl.sv | 106 ++++++++++
 tb/tb_hazard_stall_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the pipeline hazard stall/flush controller:
// Tuse/Tnew encodings, shadow-record field widths and the record types.
package hazard_stall_ctrl_pkg;

    // Tuse: how many cycles after D the operand is first consumed.
    localparam logic [1:0] TUSE_D    = 2'd0;
    localparam logic [1:0] TUSE_E    = 2'd1;
    localparam logic [1:0] TUSE_M    = 2'd2;
    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Tnew: how many cycles after entering E the result becomes available.
    localparam logic [1:0] TNEW_ZERO = 2'd0;
    localparam logic [1:0] TNEW_ALU  = 2'd1;
    localparam logic [1:0] TNEW_LOAD = 2'd2;

    // Shadow-record field widths.
    localparam int REC_ADDR_W = 5;
    localparam int REC_TNEW_W = 2;

    // MDU busy counter width; it must be able to hold the divide latency.
    localparam int MD_CNT_W = 4;

    // Destination/Tnew pair tracked for every in-flight producer.
    typedef struct packed {
        logic [REC_ADDR_W-1:0] addr;
        logic [REC_TNEW_W-1:0] tnew;
    } gpr_rec_t;

    // E-stage record: the GPR pair plus the MDU start flag and divide flag.
    // The M-stage copy keeps only the GPR pair, because the MDU flags are
    // consumed as the instruction leaves E.
    typedef struct packed {
        gpr_rec_t gpr;
        logic     md_start;
        logic     md_div;
    } e_rec_t;

    // Tnew ages by one per stage and never goes below zero.
    function automatic logic [REC_TNEW_W-1:0] tnew_age(input logic [REC_TNEW_W-1:0] t);
        return (t == '0) ? '0 : t - REC_TNEW_W'(1);
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_md_busy_counter.sv
// Multiply/divide unit busy tracker: loads the instruction latency when a
// mult/div sits in E, then counts down to zero; busy while nonzero.
module md_busy_counter
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = MD_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic load_div,
    output logic busy
);

    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: reset clears, a start reloads, otherwise count down to 0.
    always_comb begin
        cnt_d = cnt_q;
        if (reset) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_div ? DIV_LD : MULT_LD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage pipeline. Keeps shadow records of
// the destinations and Tnew of the E and M instructions, compares them with
// the D-stage operand Tuse, and stalls HI/LO users while the MDU is busy.
// One stall decision drives PC hold, D register hold and E register flush.
//
// Handshake: there is no valid/ready pair here; stall is a same-cycle
// combinational response to the D inputs and the registered records, and
// the D instruction advances into E exactly on a cycle where stall is 0.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] D_rs,
    input  logic [4:0] D_rt,
    input  logic [1:0] D_tuse_rs,
    input  logic [1:0] D_tuse_rt,
    input  logic [4:0] D_wr_addr,
    input  logic [1:0] D_tnew,
    input  logic       D_md_start,
    input  logic       D_md_div,
    input  logic       D_md_use,
    output logic       F_PC_STALL,
    output logic       D_REG_STALL,
    output logic       E_REG_FLUSH,
    output logic       md_busy
);

    e_rec_t   e_rec_q;
    e_rec_t   e_rec_d;
    gpr_rec_t m_rec_q;
    gpr_rec_t m_rec_d;

    logic rs_stall;
    logic rt_stall;
    logic md_stall;
    logic stall;

    // GPR hazard check. A Tuse of 3 can never stall because Tnew is at most
    // 2. W is not checked since its result is always ready. Register $0 is
    // hard-wired and never forms a hazard.
    always_comb begin
        rs_stall = 1'b0;
        rt_stall = 1'b0;
        if (D_rs != 5'd0) begin
            rs_stall = ((D_rs == e_rec_q.gpr.addr) && (e_rec_q.gpr.tnew > D_tuse_rs)) ||
                       ((D_rs == m_rec_q.addr)     && (m_rec_q.tnew     > D_tuse_rs));
        end
        if (D_rt != 5'd0) begin
            rt_stall = ((D_rt == e_rec_q.gpr.addr) && (e_rec_q.gpr.tnew > D_tuse_rt)) ||
                       ((D_rt == m_rec_q.addr)     && (m_rec_q.tnew     > D_tuse_rt));
        end
    end

    // HI/LO users wait while the MDU counts, and also in the cycle the
    // mult/div is in E, before the counter has been loaded.
    always_comb begin
        md_stall = D_md_use & (md_busy | e_rec_q.md_start);
        stall    = rs_stall | rt_stall | md_stall;
    end

    // Record shift: E ages into M; D enters E unless stalled, in which case
    // E receives a bubble. A stalled mult/div therefore never starts the MDU.
    always_comb begin
        m_rec_d      = e_rec_q.gpr;
        m_rec_d.tnew = tnew_age(e_rec_q.gpr.tnew);
        e_rec_d      = '0;
        if (!stall) begin
            e_rec_d.gpr.addr = D_wr_addr;
            e_rec_d.gpr.tnew = D_tnew;
            e_rec_d.md_start = D_md_start;
            e_rec_d.md_div   = D_md_div;
        end
        if (reset) begin
            m_rec_d = '0;
            e_rec_d = '0;
        end
    end

    // Shadow record registers.
    always_ff @(posedge clk) begin
        e_rec_q <= e_rec_d;
        m_rec_q <= m_rec_d;
    end

    md_busy_counter #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (MD_CNT_W)
    ) u_md_busy_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (e_rec_q.md_start),
        .load_div (e_rec_q.md_div),
        .busy     (md_busy)
    );

    // All pipeline controls are released while reset is held.
    assign F_PC_STALL  = stall & ~reset;
    assign D_REG_STALL = stall & ~reset;
    assign E_REG_FLUSH = stall & ~reset;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Testbench for hazard_stall_ctrl: directed scenarios plus random traffic
// checked against a timeline model of in-flight producers and MDU activity.
module tb_hazard_stall_ctrl;
    import hazard_stall_ctrl_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [4:0] d_rs, d_rt, d_wr_addr;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic       d_md_start, d_md_div, d_md_use;
    logic       f_pc_stall, d_reg_stall, e_reg_flush, md_busy;

    hazard_stall_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk         (clk),
        .reset       (reset),
        .D_rs        (d_rs),
        .D_rt        (d_rt),
        .D_tuse_rs   (d_tuse_rs),
        .D_tuse_rt   (d_tuse_rt),
        .D_wr_addr   (d_wr_addr),
        .D_tnew      (d_tnew),
        .D_md_start  (d_md_start),
        .D_md_div    (d_md_div),
        .D_md_use    (d_md_use),
        .F_PC_STALL  (f_pc_stall),
        .D_REG_STALL (d_reg_stall),
        .E_REG_FLUSH (e_reg_flush),
        .md_busy     (md_busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    // Each issued instruction is remembered with the absolute cycle it sat in
    // E; its remaining latency at cycle t is (issue + tnew - t), floored at 0.
    typedef struct {
        int         issue;
        logic [4:0] addr;
        int         tnew;
    } ent_t;
    ent_t ent_q[$];

    int   cyc = 0;
    bit   md_valid = 0;
    int   md_s = 0;
    int   md_n = 0;
    bit   pending = 0;
    logic exp_stall;
    logic exp_busy;
    logic [0:0] exp_q[$];

    task automatic model_eval();
        exp_stall = 1'b0;
        foreach (ent_q[i]) begin
            int age;
            int rem;
            age = cyc - ent_q[i].issue;
            if (age == 0 || age == 1) begin
                rem = ent_q[i].issue + ent_q[i].tnew - cyc;
                if (rem < 0) rem = 0;
                if (d_rs != 0 && d_rs == ent_q[i].addr && rem > int'(d_tuse_rs)) exp_stall = 1'b1;
                if (d_rt != 0 && d_rt == ent_q[i].addr && rem > int'(d_tuse_rt)) exp_stall = 1'b1;
            end
        end
        exp_busy = md_valid && (cyc >= md_s + 1) && (cyc <= md_s + md_n);
        if (d_md_use && md_valid && cyc >= md_s && cyc <= md_s + md_n) exp_stall = 1'b1;
        if (reset) exp_stall = 1'b0;
    endtask

    task automatic model_commit();
        if (reset) begin
            ent_q.delete();
            md_valid = 0;
        end else if (!exp_stall) begin
            ent_t e;
            e.issue = cyc + 1;
            e.addr  = d_wr_addr;
            e.tnew  = int'(d_tnew);
            ent_q.push_back(e);
            if (d_md_start) begin
                md_valid = 1;
                md_s     = cyc + 1;
                md_n     = d_md_div ? DIV_N : MULT_N;
            end
        end
        while (ent_q.size() > 0 && ent_q[0].issue < cyc) void'(ent_q.pop_front());
        cyc++;
    endtask

    // ---------------- driver ----------------
    // Drives one cycle of D-stage inputs away from the clock edge and
    // evaluates the model for that cycle.
    task automatic apply(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [1:0] tur, input logic [1:0] tut,
                         input logic [4:0] wr, input logic [1:0] tn,
                         input logic mds, input logic mdd, input logic mdu);
        if (pending) model_commit();
        @(negedge clk);
        reset = rst; d_rs = rs; d_rt = rt; d_tuse_rs = tur; d_tuse_rt = tut;
        d_wr_addr = wr; d_tnew = tn; d_md_start = mds; d_md_div = mdd; d_md_use = mdu;
        #1;
        model_eval();
        pending = 1;
    endtask

    task automatic neutral(input int n);
        for (int i = 0; i < n; i++)
            apply(1'b0, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd0, TNEW_ZERO, 1'b0, 1'b0, 1'b0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        // Hazard-looking inputs while in reset must still give no stall.
        apply(1'b1, 5'd1, 5'd1, TUSE_D, TUSE_D, 5'd1, TNEW_LOAD, 1'b0, 1'b0, 1'b1);
        apply(1'b1, 5'd1, 5'd1, TUSE_D, TUSE_D, 5'd1, TNEW_LOAD, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if ({f_pc_stall, d_reg_stall, e_reg_flush} !== 3'b000) begin
            n_err++; $display("FAIL reset_outputs: got %b expected 000", {f_pc_stall, d_reg_stall, e_reg_flush});
        end
        n_cmp++;
        if (md_busy !== 1'b0) begin
            n_err++; $display("FAIL reset_md_busy: got %b expected 0", md_busy);
        end
        apply(1'b0, 5'd1, 5'd2, TUSE_D, TUSE_D, 5'd0, TNEW_ZERO, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if ({f_pc_stall, d_reg_stall, e_reg_flush, md_busy} !== 4'b0000) begin
            n_err++; $display("FAIL reset_release: got %b expected 0000", {f_pc_stall, d_reg_stall, e_reg_flush, md_busy});
        end
        neutral(1);
    endtask

    task automatic test_load_use();
        logic [2:0] exp_s[3] = '{3'b000, 3'b111, 3'b000};
        // lw $1 ; add $3,$1 (tuse 1) held while stalled ; then neutral.
        for (int i = 0; i < 3; i++) begin
            if (i == 0) apply(1'b0, 5'd2, 5'd0, TUSE_E, TUSE_NONE, 5'd1, TNEW_LOAD, 1'b0, 1'b0, 1'b0);
            else        apply(1'b0, 5'd1, 5'd0, TUSE_E, TUSE_NONE, 5'd3, TNEW_ALU, 1'b0, 1'b0, 1'b0);
            n_cmp++;
            if ({f_pc_stall, d_reg_stall, e_reg_flush} !== exp_s[i]) begin
                n_err++; $display("FAIL load_use c%0d: got %b expected %b", i, {f_pc_stall, d_reg_stall, e_reg_flush}, exp_s[i]);
            end
        end
        // The add entered E; a tuse-0 reader of $3 must now stall on it.
        apply(1'b0, 5'd0, 5'd3, TUSE_NONE, TUSE_D, 5'd0, TNEW_ZERO, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (d_reg_stall !== 1'b1) begin
            n_err++; $display("FAIL load_use_next: got %b expected 1", d_reg_stall);
        end
        neutral(3);
    endtask

    task automatic test_branch_load();
        logic [2:0] exp_s[4] = '{3'b000, 3'b111, 3'b111, 3'b000};
        for (int i = 0; i < 4; i++) begin
            if (i == 0) apply(1'b0, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd1, TNEW_LOAD, 1'b0, 1'b0, 1'b0);
            else        apply(1'b0, 5'd1, 5'd4, TUSE_D, TUSE_D, 5'd0, TNEW_ZERO, 1'b0, 1'b0, 1'b0);
            n_cmp++;
            if ({f_pc_stall, d_reg_stall, e_reg_flush} !== exp_s[i]) begin
                n_err++; $display("FAIL branch_load c%0d: got %b expected %b", i, {f_pc_stall, d_reg_stall, e_reg_flush}, exp_s[i]);
            end
        end
        neutral(3);
    endtask

    task automatic test_zero_reg();
        apply(1'b0, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd0, TNEW_LOAD, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 5'd0, 5'd0, TUSE_D, TUSE_D, 5'd0, TNEW_LOAD, 1'b0, 1'b0, 1'b0);
            n_cmp++;
            if (d_reg_stall !== 1'b0) begin
                n_err++; $display("FAIL zero_reg c%0d: got %b expected 0", i, d_reg_stall);
            end
        end
        neutral(3);
    endtask

    task automatic test_mdu(input logic is_div);
        int n;
        n = is_div ? DIV_N : MULT_N;
        apply(1'b0, 5'd2, 5'd3, TUSE_E, TUSE_E, 5'd0, TNEW_ZERO, 1'b1, is_div, 1'b1);
        n_cmp++;
        if ({d_reg_stall, md_busy} !== 2'b00) begin
            n_err++; $display("FAIL mdu_issue div=%0d: got %b expected 00", is_div, {d_reg_stall, md_busy});
        end
        // mflo waits for the E cycle plus the whole busy window.
        for (int i = 0; i <= n; i++) exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        for (int i = 0; i <= n + 1; i++) begin
            logic [0:0] e;
            e = exp_q.pop_front();
            apply(1'b0, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd8, TNEW_ALU, 1'b0, 1'b0, 1'b1);
            n_cmp++;
            if ({f_pc_stall, d_reg_stall, e_reg_flush} !== {3{e}}) begin
                n_err++; $display("FAIL mdu_stall div=%0d c%0d: got %b expected %b", is_div, i, {f_pc_stall, d_reg_stall, e_reg_flush}, {3{e}});
            end
            n_cmp++;
            if (md_busy !== logic'(i >= 1 && i <= n)) begin
                n_err++; $display("FAIL mdu_busy div=%0d c%0d: got %b expected %b", is_div, i, md_busy, (i >= 1 && i <= n));
            end
        end
        neutral(2);
    endtask

    task automatic test_reset_mid_stall();
        apply(1'b0, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd1, TNEW_LOAD, 1'b1, 1'b1, 1'b1);
        apply(1'b0, 5'd1, 5'd0, TUSE_D, TUSE_NONE, 5'd0, TNEW_ZERO, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (d_reg_stall !== 1'b1) begin
            n_err++; $display("FAIL rst_mid_first: got %b expected 1", d_reg_stall);
        end
        apply(1'b1, 5'd1, 5'd0, TUSE_D, TUSE_NONE, 5'd0, TNEW_ZERO, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if ({f_pc_stall, d_reg_stall, e_reg_flush} !== 3'b000) begin
            n_err++; $display("FAIL rst_mid_during: got %b expected 000", {f_pc_stall, d_reg_stall, e_reg_flush});
        end
        // Same consumer plus an HI/LO use: records and counter are cleared.
        apply(1'b0, 5'd1, 5'd0, TUSE_D, TUSE_NONE, 5'd0, TNEW_ZERO, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if ({f_pc_stall, d_reg_stall, e_reg_flush, md_busy} !== 4'b0000) begin
            n_err++; $display("FAIL rst_mid_after: got %b expected 0000", {f_pc_stall, d_reg_stall, e_reg_flush, md_busy});
        end
        neutral(2);
    endtask

    task automatic test_forward();
        apply(1'b0, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd5, TNEW_ALU, 1'b0, 1'b0, 1'b0);
        neutral(1);
        apply(1'b0, 5'd5, 5'd5, TUSE_D, TUSE_D, 5'd0, TNEW_ZERO, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (d_reg_stall !== 1'b0) begin
            n_err++; $display("FAIL forward_m: got %b expected 0", d_reg_stall);
        end
        neutral(2);
    endtask

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) begin
            logic mds;
            logic mdu;
            mds = ($urandom_range(0, 9) == 0);
            mdu = mds | ($urandom_range(0, 7) == 0);
            apply(($urandom_range(0, 59) == 0),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 2'($urandom_range(0, 2)),
                  mds, 1'($urandom_range(0, 1)), mdu);
            n_cmp++;
            if ({f_pc_stall, d_reg_stall, e_reg_flush} !== {3{exp_stall}}) begin
                n_err++; $display("FAIL random_stall c%0d: got %b expected %b", cyc, {f_pc_stall, d_reg_stall, e_reg_flush}, {3{exp_stall}});
            end
            n_cmp++;
            if (md_busy !== exp_busy) begin
                n_err++; $display("FAIL random_busy c%0d: got %b expected %b", cyc, md_busy, exp_busy);
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        reset = 1'b1; d_rs = '0; d_rt = '0; d_tuse_rs = TUSE_NONE; d_tuse_rt = TUSE_NONE;
        d_wr_addr = '0; d_tnew = '0; d_md_start = 1'b0; d_md_div = 1'b0; d_md_use = 1'b0;
        test_reset();
        test_load_use();
        test_branch_load();
        test_zero_reg();
        test_mdu(1'b1);
        test_mdu(1'b0);
        test_reset_mid_stall();
        test_forward();
        test_random(800);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
